memory_word_sequencer: RTL and testbench

//  Upstream master for the byte-wide Memory block. Each 16-bit word request from the
//  CPU side (fetch/load/store) becomes two byte accesses on the memory bus, one per clock.

---
 rtl/mem_seq_pkg.sv | 22 ++
 rtl/memory_word_sequencer.sv | 118 +++++++++++
 tb/tb_memory_word_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared types and constants for the memory word sequencer
package mem_seq_pkg;

   localparam int ADDR_WIDTH_DEF = 16;
   localparam int BYTE_WIDTH_DEF = 8;

   // Memory-side strobe encodings; cs is active-low on the Memory block.
   localparam logic CS_ACTIVE = 1'b0;
   localparam logic CS_IDLE   = 1'b1;
   localparam logic WR_WRITE  = 1'b1;
   localparam logic WR_READ   = 1'b0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      RESP  = 3'd5
   } seq_state_t;

endpackage

// File: rtl/memory_word_sequencer.sv
// rtl/memory_word_sequencer.sv - splits 16-bit word requests into two little-endian byte accesses
module memory_word_sequencer
   import mem_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int BYTE_WIDTH = BYTE_WIDTH_DEF
) (
   input  logic                    Clock,
   input  logic                    Reset_n,
   input  logic                    Req_Valid,
   output logic                    Req_Ready,
   input  logic                    Req_Write,
   input  logic [ADDR_WIDTH-1:0]   Req_Address,
   input  logic [2*BYTE_WIDTH-1:0] Req_WData,
   output logic                    Rsp_Valid,
   input  logic                    Rsp_Ready,
   output logic [2*BYTE_WIDTH-1:0] Rsp_RData,
   output logic [ADDR_WIDTH-1:0]   Mem_Address,
   output logic [BYTE_WIDTH-1:0]   Mem_Data,
   output logic                    Mem_WR,
   output logic                    Mem_CS,
   input  logic [BYTE_WIDTH-1:0]   Mem_RData
);

   seq_state_t                state;
   seq_state_t                state_next;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [ADDR_WIDTH-1:0]     addr_hi;
   logic [2*BYTE_WIDTH-1:0]   wdata_q;
   logic                      write_q;
   logic [BYTE_WIDTH-1:0]     lo_q;
   logic [2*BYTE_WIDTH-1:0]   rdata_q;

   // Wraps naturally at 2^ADDR_WIDTH through truncation.
   assign addr_hi   = addr_q + ADDR_WIDTH'(1);
   assign Rsp_RData = rdata_q;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         lo_q    <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && Req_Valid) begin
            addr_q  <= Req_Address;
            wdata_q <= Req_WData;
            write_q <= Req_Write;
         end
         if (state == RD_LO) begin
            lo_q <= Mem_RData;
         end
         if (state == RD_HI) begin
            rdata_q <= {Mem_RData, lo_q};
         end
      end
   end

   // Memory strobes come only from state and latched registers, so reset
   // forces cs inactive immediately and no request input reaches the bus.
   always_comb begin
      state_next  = state;
      Req_Ready   = 1'b0;
      Rsp_Valid   = 1'b0;
      Mem_CS      = CS_IDLE;
      Mem_WR      = WR_READ;
      Mem_Address = '0;
      Mem_Data    = '0;
      case (state)
         IDLE: begin
            Req_Ready = 1'b1;
            if (Req_Valid) begin
               state_next = Req_Write ? WR_LO : RD_LO;
            end
         end
         RD_LO: begin
            Mem_CS      = CS_ACTIVE;
            Mem_Address = addr_q;
            state_next  = RD_HI;
         end
         RD_HI: begin
            Mem_CS      = CS_ACTIVE;
            Mem_Address = addr_hi;
            state_next  = RESP;
         end
         WR_LO: begin
            Mem_CS      = CS_ACTIVE;
            Mem_WR      = WR_WRITE;
            Mem_Address = addr_q;
            Mem_Data    = wdata_q[BYTE_WIDTH-1:0];
            state_next  = WR_HI;
         end
         WR_HI: begin
            Mem_CS      = CS_ACTIVE;
            Mem_WR      = WR_WRITE;
            Mem_Address = addr_hi;
            Mem_Data    = wdata_q[2*BYTE_WIDTH-1:BYTE_WIDTH];
            state_next  = RESP;
         end
         RESP: begin
            Rsp_Valid = 1'b1;
            if (Rsp_Ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   logic unused_write;
   assign unused_write = write_q;

endmodule

// File: tb/tb_memory_word_sequencer.sv
// tb/tb_memory_word_sequencer.sv - directed bench for memory_word_sequencer with a byte RAM model
module tb_memory_word_sequencer;
   import mem_seq_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_address;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_rdata;
   logic [15:0] mem_address;
   logic [7:0]  mem_data;
   logic        mem_wr;
   logic        mem_cs;
   logic [7:0]  mem_rdata;

   logic [7:0]  ram [0:65535];
   int          vectors;
   int          miscompares;
   int          strobe_violations;

   memory_word_sequencer #(.ADDR_WIDTH(16), .BYTE_WIDTH(8)) dut (
      .Clock       (clk),
      .Reset_n     (rst_n),
      .Req_Valid   (req_valid),
      .Req_Ready   (req_ready),
      .Req_Write   (req_write),
      .Req_Address (req_address),
      .Req_WData   (req_wdata),
      .Rsp_Valid   (rsp_valid),
      .Rsp_Ready   (rsp_ready),
      .Rsp_RData   (rsp_rdata),
      .Mem_Address (mem_address),
      .Mem_Data    (mem_data),
      .Mem_WR      (mem_wr),
      .Mem_CS      (mem_cs),
      .Mem_RData   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-wide memory: combinational read, write on the rising edge when selected.
   assign mem_rdata = ram[mem_address];
   always @(posedge clk) begin
      if (mem_cs == CS_ACTIVE && mem_wr == WR_WRITE) ram[mem_address] <= mem_data;
   end

   always @(negedge clk) begin
      if (mem_cs == CS_IDLE && mem_wr == WR_WRITE) strobe_violations++;
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Starts at a negedge with the DUT idle and rsp_ready high; ends at a negedge back in IDLE.
   task automatic run_txn(input string tag, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] exp_rd, input bit chk_rd);
      logic [15:0] a1;
      a1 = a + 16'd1;
      req_valid = 1'b1; req_write = wr; req_address = a; req_wdata = wd;
      check_vec({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      check_vec({tag, "_lo_cs"}, 32'(mem_cs), 32'(CS_ACTIVE));
      check_vec({tag, "_lo_addr"}, 32'(mem_address), 32'(a));
      check_vec({tag, "_lo_wr"}, 32'(mem_wr), 32'(wr));
      if (wr) check_vec({tag, "_lo_data"}, 32'(mem_data), 32'(wd[7:0]));
      check_vec({tag, "_lo_busy"}, 32'(req_ready), 32'd0);
      @(posedge clk); @(negedge clk);
      check_vec({tag, "_hi_addr"}, 32'(mem_address), 32'(a1));
      check_vec({tag, "_hi_wr"}, 32'(mem_wr), 32'(wr));
      if (wr) check_vec({tag, "_hi_data"}, 32'(mem_data), 32'(wd[15:8]));
      check_vec({tag, "_hi_rsp_low"}, 32'(rsp_valid), 32'd0);
      @(posedge clk); @(negedge clk);
      check_vec({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check_vec({tag, "_rsp_cs"}, 32'(mem_cs), 32'(CS_IDLE));
      if (chk_rd) check_vec({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
      @(posedge clk); @(negedge clk);
      check_vec({tag, "_back_idle"}, 32'(req_ready), 32'd1);
      check_vec({tag, "_rsp_clear"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int accept_cycle [$];
      vectors = 0; miscompares = 0; strobe_violations = 0;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      ram[16'h0010] = 8'h34; ram[16'h0011] = 8'h12;
      ram[16'hFFFF] = 8'h77; ram[16'h0000] = 8'h99;
      ram[16'h0031] = 8'hC3;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_address = '0; req_wdata = '0; rsp_ready = 1'b1;
      repeat (2) @(negedge clk);

      check_vec("rst_cs", 32'(mem_cs), 32'd1);
      check_vec("rst_wr", 32'(mem_wr), 32'd0);
      check_vec("rst_addr", 32'(mem_address), 32'd0);
      check_vec("rst_data", 32'(mem_data), 32'd0);
      check_vec("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_vec("rst_rdata", 32'(rsp_rdata), 32'd0);
      check_vec("rst_req_ready", 32'(req_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      run_txn("rd10", 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b1);

      run_txn("wr20", 1'b1, 16'h0020, 16'hBEEF, 16'h0000, 1'b0);
      check_vec("wr20_ram20", 32'(ram[16'h0020]), 32'h EF);
      check_vec("wr20_ram21", 32'(ram[16'h0021]), 32'h BE);
      check_vec("wr20_rdata_held", 32'(rsp_rdata), 32'h1234);
      run_txn("rb20", 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b1);

      run_txn("rdffff", 1'b0, 16'hFFFF, 16'h0000, 16'h9977, 1'b1);

      // Response back-pressure: stalled for 3 cycles while a new request is offered.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_address = 16'h0010;
      @(posedge clk); @(negedge clk);
      req_write = 1'b1; req_address = 16'h0040; req_wdata = 16'hDEAD;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         check_vec($sformatf("stall%0d_valid", c), 32'(rsp_valid), 32'd1);
         check_vec($sformatf("stall%0d_rdata", c), 32'(rsp_rdata), 32'h1234);
         check_vec($sformatf("stall%0d_ready", c), 32'(req_ready), 32'd0);
         check_vec($sformatf("stall%0d_cs", c), 32'(mem_cs), 32'd1);
         @(posedge clk); @(negedge clk);
      end
      req_valid = 1'b0;
      check_vec("stall_still_valid", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check_vec("stall_release_idle", 32'(req_ready), 32'd1);
      check_vec("stall_release_rsp", 32'(rsp_valid), 32'd0);
      check_vec("stall_ignored_req", 32'(ram[16'h0040]), 32'h00);

      // Reset during the high-byte write cycle: only the low byte may land.
      req_valid = 1'b1; req_write = 1'b1; req_address = 16'h0030; req_wdata = 16'hA55A;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check_vec("abort_in_wr_hi", 32'(mem_address), 32'h0031);
      #1 rst_n = 1'b0;
      #1;
      check_vec("abort_cs_async", 32'(mem_cs), 32'd1);
      check_vec("abort_wr_low", 32'(mem_wr), 32'd0);
      check_vec("abort_idle", 32'(req_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_vec("abort_ram30", 32'(ram[16'h0030]), 32'h5A);
      check_vec("abort_ram31", 32'(ram[16'h0031]), 32'hC3);
      check_vec("abort_ready", 32'(req_ready), 32'd1);

      // Back-to-back writes with Req_Valid held high.
      req_valid = 1'b1; req_write = 1'b1; req_address = 16'h0050; req_wdata = 16'h1111;
      for (int c = 0; c < 16; c++) begin
         if (req_ready) accept_cycle.push_back(c);
         @(posedge clk); @(negedge clk);
      end
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      check_vec("b2b_accepts", 32'(accept_cycle.size()), 32'd4);
      for (int i = 1; i < accept_cycle.size(); i++) begin
         check_vec($sformatf("b2b_gap%0d", i), 32'(accept_cycle[i] - accept_cycle[i-1]), 32'd4);
      end
      check_vec("b2b_ram50", 32'(ram[16'h0050]), 32'h11);
      check_vec("b2b_ram51", 32'(ram[16'h0051]), 32'h11);
      check_vec("wr_without_cs", 32'(strobe_violations), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
